// File: rtl/pifo_pkg.sv
// Shared widths, field offsets and types for the per-port PIFO rank queue.
// Entry layout (MSB..LSB): {port_id, class, round, info}; last_pkt_info is {round, info}.
package pifo_pkg;

    localparam int PIFO_ROUND_WIDTH    = 20;
    localparam int PIFO_CLASS_WIDTH    = 5;
    localparam int PIFO_PORT_ID_WIDTH  = 3;
    localparam int PIFO_INFO_WIDTH     = 12;
    localparam int PIFO_DEPTH          = 16;
    localparam int PIFO_CNT_WIDTH      = 5;
    localparam int PIFO_DROP_CNT_WIDTH = 16;
    localparam int PIFO_ENTRY_WIDTH    = PIFO_PORT_ID_WIDTH + PIFO_CLASS_WIDTH
                                       + PIFO_ROUND_WIDTH + PIFO_INFO_WIDTH;

    localparam int PORT_ID_LSB = 37;
    localparam int CLASS_LSB   = 32;
    localparam int ROUND_LSB   = 12;
    localparam int INFO_LSB    = 0;

    localparam int LAST_ROUND_LSB = 12;
    localparam int LAST_INFO_LSB  = 0;
    localparam int LAST_WIDTH     = PIFO_ROUND_WIDTH + PIFO_INFO_WIDTH;

    typedef struct packed {
        logic [PIFO_PORT_ID_WIDTH-1:0] port_id;
        logic [PIFO_CLASS_WIDTH-1:0]   class_id;
        logic [PIFO_ROUND_WIDTH-1:0]   round;
        logic [PIFO_INFO_WIDTH-1:0]    info;
    } pifo_entry_t;

    typedef enum logic [1:0] {
        SLOT_HOLD       = 2'd0,
        SLOT_SHIFT_UP   = 2'd1,
        SLOT_SHIFT_DOWN = 2'd2,
        SLOT_LOAD       = 2'd3
    } slot_op_e;

endpackage

// File: rtl/pifo_slot.sv
// One PIFO storage slot: valid bit plus entry, with its own round compare
// against the incoming entry and a 4-way next-value select driven by the top.
module pifo_slot
    import pifo_pkg::*;
#(
    parameter int ENTRY_WIDTH = PIFO_ENTRY_WIDTH,
    parameter int ROUND_WIDTH = PIFO_ROUND_WIDTH,
    parameter int RND_LSB     = PIFO_INFO_WIDTH
)(
    input  logic                   clk_dp,
    input  logic                   rst,
    input  slot_op_e               i_op,
    input  logic [ENTRY_WIDTH-1:0] i_new_entry,
    input  logic                   i_lower_valid,
    input  logic [ENTRY_WIDTH-1:0] i_lower_entry,
    input  logic                   i_upper_valid,
    input  logic [ENTRY_WIDTH-1:0] i_upper_entry,
    output logic                   o_valid,
    output logic [ENTRY_WIDTH-1:0] o_entry,
    output logic                   o_le
);

    logic                   r_valid;
    logic [ENTRY_WIDTH-1:0] r_entry;
    logic                   w_next_valid;
    logic [ENTRY_WIDTH-1:0] w_next_entry;

    // Invalid slots never count toward the insert position.
    assign o_le    = r_valid &&
                     (r_entry[RND_LSB +: ROUND_WIDTH] <= i_new_entry[RND_LSB +: ROUND_WIDTH]);
    assign o_valid = r_valid;
    assign o_entry = r_entry;

    always_comb begin
        w_next_valid = r_valid;
        w_next_entry = r_entry;
        case (i_op)
            SLOT_SHIFT_UP: begin
                w_next_valid = i_lower_valid;
                w_next_entry = i_lower_entry;
            end
            SLOT_SHIFT_DOWN: begin
                w_next_valid = i_upper_valid;
                w_next_entry = i_upper_entry;
            end
            SLOT_LOAD: begin
                w_next_valid = 1'b1;
                w_next_entry = i_new_entry;
            end
            default: begin
                w_next_valid = r_valid;
                w_next_entry = r_entry;
            end
        endcase
    end

    always_ff @(posedge clk_dp) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else begin
            r_valid <= w_next_valid;
            r_entry <= w_next_entry;
        end
    end

endmodule

// File: rtl/pifo_rank_queue.sv
// Per-port push-in-first-out queue sorted by round (ties FIFO); slot 0 is the head.
// Owns occupancy, insert-position encoding, dequeue output registers and drop counting.
module pifo_rank_queue
    import pifo_pkg::*;
#(
    parameter int ROUND_WIDTH     = PIFO_ROUND_WIDTH,
    parameter int CLASS_WIDTH     = PIFO_CLASS_WIDTH,
    parameter int PORT_ID_WIDTH   = PIFO_PORT_ID_WIDTH,
    parameter int PIFO_INFO_WIDTH = pifo_pkg::PIFO_INFO_WIDTH,
    parameter int DEPTH           = PIFO_DEPTH,
    parameter int CNT_WIDTH       = PIFO_CNT_WIDTH,
    parameter int DROP_CNT_WIDTH  = PIFO_DROP_CNT_WIDTH,
    parameter int ENTRY_WIDTH     = PORT_ID_WIDTH + CLASS_WIDTH + ROUND_WIDTH + PIFO_INFO_WIDTH
)(
    input  logic                                  clk_dp,
    input  logic                                  rst,
    input  logic                                  enq_valid,
    input  logic [ENTRY_WIDTH-1:0]                enq_data,
    input  logic                                  deq_req,
    output logic                                  deq_valid,
    output logic [ENTRY_WIDTH-1:0]                deq_data,
    output logic [ROUND_WIDTH+PIFO_INFO_WIDTH-1:0] last_pkt_info,
    output logic [CNT_WIDTH-1:0]                  count,
    output logic                                  full,
    output logic                                  empty,
    output logic [DROP_CNT_WIDTH-1:0]             drop_count
);

    localparam int                   INFO_ROUND_WIDTH = ROUND_WIDTH + PIFO_INFO_WIDTH;
    localparam logic [CNT_WIDTH-1:0] DEPTH_CNT        = CNT_WIDTH'(DEPTH);

    logic                          r_deq_valid;
    logic [ENTRY_WIDTH-1:0]        r_deq_data;
    logic [INFO_ROUND_WIDTH-1:0]   r_last_info;
    logic [CNT_WIDTH-1:0]          r_count;
    logic [DROP_CNT_WIDTH-1:0]     r_drop_count;

    logic [DEPTH-1:0]              w_slot_valid;
    logic [DEPTH-1:0]              w_slot_le;
    logic [ENTRY_WIDTH-1:0]        w_slot_entry [DEPTH];
    slot_op_e                      w_op [DEPTH];

    logic                          w_do_deq;
    logic                          w_do_enq;
    logic                          w_drop;
    logic [CNT_WIDTH-1:0]          w_pos;
    logic [CNT_WIDTH-1:0]          w_ins_pos;

    assign full          = (r_count == DEPTH_CNT);
    assign empty         = (r_count == '0);
    assign count         = r_count;
    assign deq_valid     = r_deq_valid;
    assign deq_data      = r_deq_data;
    assign last_pkt_info = r_last_info;
    assign drop_count    = r_drop_count;

    // A dequeue frees a slot, so a full queue still accepts a same-cycle enqueue.
    assign w_do_deq = deq_req && !empty;
    assign w_do_enq = enq_valid && (!full || w_do_deq);
    assign w_drop   = enq_valid && full && !deq_req;

    // Valid slots are sorted, so the "<=" bits form a prefix and their popcount is the insert index.
    always_comb begin
        w_pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_pos = w_pos + CNT_WIDTH'(w_slot_le[i]);
        end
        w_ins_pos = (w_do_deq && (w_pos != '0)) ? (w_pos - 1'b1) : w_pos;
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_op[i] = SLOT_HOLD;
            if (w_do_enq && !w_do_deq) begin
                if (CNT_WIDTH'(i) == w_ins_pos) begin
                    w_op[i] = SLOT_LOAD;
                end else if (CNT_WIDTH'(i) > w_ins_pos) begin
                    w_op[i] = SLOT_SHIFT_UP;
                end
            end else if (w_do_enq && w_do_deq) begin
                if (CNT_WIDTH'(i) < w_ins_pos) begin
                    w_op[i] = SLOT_SHIFT_DOWN;
                end else if (CNT_WIDTH'(i) == w_ins_pos) begin
                    w_op[i] = SLOT_LOAD;
                end
            end else if (w_do_deq) begin
                w_op[i] = SLOT_SHIFT_DOWN;
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        logic                   w_lower_valid;
        logic [ENTRY_WIDTH-1:0] w_lower_entry;
        logic                   w_upper_valid;
        logic [ENTRY_WIDTH-1:0] w_upper_entry;

        if (g == 0) begin : g_bottom
            assign w_lower_valid = 1'b0;
            assign w_lower_entry = '0;
        end else begin : g_mid_lo
            assign w_lower_valid = w_slot_valid[g-1];
            assign w_lower_entry = w_slot_entry[g-1];
        end

        if (g == DEPTH-1) begin : g_top
            assign w_upper_valid = 1'b0;
            assign w_upper_entry = '0;
        end else begin : g_mid_hi
            assign w_upper_valid = w_slot_valid[g+1];
            assign w_upper_entry = w_slot_entry[g+1];
        end

        pifo_slot #(
            .ENTRY_WIDTH (ENTRY_WIDTH),
            .ROUND_WIDTH (ROUND_WIDTH),
            .RND_LSB     (PIFO_INFO_WIDTH)
        ) u_slot (
            .clk_dp        (clk_dp),
            .rst           (rst),
            .i_op          (w_op[g]),
            .i_new_entry   (enq_data),
            .i_lower_valid (w_lower_valid),
            .i_lower_entry (w_lower_entry),
            .i_upper_valid (w_upper_valid),
            .i_upper_entry (w_upper_entry),
            .o_valid       (w_slot_valid[g]),
            .o_entry       (w_slot_entry[g]),
            .o_le          (w_slot_le[g])
        );
    end

    // Round and info sit in the low bits of an entry, so {round, info} is a plain low slice.
    always_ff @(posedge clk_dp) begin
        if (!rst) begin
            r_deq_valid  <= 1'b0;
            r_deq_data   <= '0;
            r_last_info  <= '0;
            r_count      <= '0;
            r_drop_count <= '0;
        end else begin
            r_deq_valid <= w_do_deq;
            if (w_do_deq) begin
                r_deq_data  <= w_slot_entry[0];
                r_last_info <= w_slot_entry[0][INFO_ROUND_WIDTH-1:0];
            end
            if (w_do_enq && !w_do_deq) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_deq && !w_do_enq) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pifo_rank_queue.sv
// Directed testbench for pifo_rank_queue: expected dequeues go into a scoreboard
// queue, and a negedge monitor pops and compares whenever deq_valid is presented.
module tb_pifo_rank_queue;

    logic        clk_dp = 1'b0;
    logic        rst;
    logic        enqValid;
    logic [39:0] enqData;
    logic        deqReq;
    logic        deqValid;
    logic [39:0] deqData;
    logic [31:0] lastPktInfo;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic [15:0] dropCount;

    int          nAsserts = 0;
    int          nFails   = 0;
    logic [39:0] expQ[$];
    logic [39:0] monExp;

    always #5 clk_dp = ~clk_dp;

    pifo_rank_queue dut (
        .clk_dp        (clk_dp),
        .rst           (rst),
        .enq_valid     (enqValid),
        .enq_data      (enqData),
        .deq_req       (deqReq),
        .deq_valid     (deqValid),
        .deq_data      (deqData),
        .last_pkt_info (lastPktInfo),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .drop_count    (dropCount)
    );

    // Port and class are derived from info so that every field is carried and checked.
    function automatic logic [39:0] mkEntry(input logic [19:0] round, input logic [11:0] info);
        return {info[2:0], info[7:3], round, info};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nAsserts++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit doEnq, input logic [19:0] round, input logic [11:0] info,
                                 input bit doDeq);
        enqValid = doEnq;
        enqData  = doEnq ? mkEntry(round, info) : 40'h0;
        deqReq   = doDeq;
        @(posedge clk_dp);
        #1;
        enqValid = 1'b0;
        deqReq   = 1'b0;
    endtask

    task automatic enq(input logic [19:0] round, input logic [11:0] info);
        applyStimulus(1'b1, round, info, 1'b0);
    endtask

    task automatic deq(input logic [19:0] round, input logic [11:0] info);
        expQ.push_back(mkEntry(round, info));
        applyStimulus(1'b0, 20'h0, 12'h0, 1'b1);
    endtask

    always @(negedge clk_dp) begin
        if (deqValid === 1'b1) begin
            if (expQ.size() == 0) begin
                nAsserts++;
                nFails++;
                $display("[TB] FAIL unexpected_deq: got deq_valid=1 data 0x%0h, expected no dequeue", deqData);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("deq_data", 64'(deqData), 64'(monExp));
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b0;
        enqValid = 1'b0;
        enqData  = 40'h0;
        deqReq   = 1'b0;
        repeat (2) @(posedge clk_dp);
        #1;
        rst = 1'b1;
        checkOutput("reset_count", 64'(count), 64'd0);
        checkOutput("reset_empty", 64'(empty), 64'd1);
        checkOutput("reset_full", 64'(full), 64'd0);
        checkOutput("reset_deq_valid", 64'(deqValid), 64'd0);
        checkOutput("reset_deq_data", 64'(deqData), 64'd0);
        checkOutput("reset_last_info", 64'(lastPktInfo), 64'd0);
        checkOutput("reset_drop", 64'(dropCount), 64'd0);

        $display("[TB] basic ordering");
        enq(20'd5, 12'hA);
        enq(20'd2, 12'hB);
        enq(20'd9, 12'hC);
        checkOutput("t1_count", 64'(count), 64'd3);
        deq(20'd2, 12'hB);
        deq(20'd5, 12'hA);
        deq(20'd9, 12'hC);
        checkOutput("t1_last_info", 64'(lastPktInfo), 64'({20'd9, 12'hC}));
        checkOutput("t1_empty", 64'(empty), 64'd1);

        $display("[TB] ties stay FIFO");
        enq(20'd4, 12'h001);
        enq(20'd4, 12'h002);
        deq(20'd4, 12'h001);
        deq(20'd4, 12'h002);

        $display("[TB] fill, drop, drain");
        for (int r = 16; r >= 1; r--) enq(20'(r), 12'(r) + 12'h100);
        checkOutput("t3_full_before_drop", 64'(full), 64'd1);
        enq(20'd0, 12'hFFF);
        checkOutput("t3_full", 64'(full), 64'd1);
        checkOutput("t3_count", 64'(count), 64'd16);
        checkOutput("t3_drop", 64'(dropCount), 64'd1);
        for (int r = 1; r <= 16; r++) deq(20'(r), 12'(r) + 12'h100);
        checkOutput("t3_empty", 64'(empty), 64'd1);

        $display("[TB] simultaneous enqueue and dequeue");
        enq(20'd3, 12'h030);
        enq(20'd7, 12'h070);
        expQ.push_back(mkEntry(20'd3, 12'h030));
        applyStimulus(1'b1, 20'd1, 12'h010, 1'b1);
        checkOutput("t4_count", 64'(count), 64'd2);
        deq(20'd1, 12'h010);
        deq(20'd7, 12'h070);

        $display("[TB] dequeue while empty");
        enq(20'd9, 12'hC);
        deq(20'd9, 12'hC);
        applyStimulus(1'b0, 20'h0, 12'h0, 1'b1);
        checkOutput("t5_deq_valid", 64'(deqValid), 64'd0);
        checkOutput("t5_last_info", 64'(lastPktInfo), 64'({20'd9, 12'hC}));
        checkOutput("t5_deq_data", 64'(deqData), 64'(mkEntry(20'd9, 12'hC)));
        applyStimulus(1'b1, 20'd6, 12'h066, 1'b1);
        checkOutput("t5_enq_deq_valid", 64'(deqValid), 64'd0);
        checkOutput("t5_count", 64'(count), 64'd1);
        deq(20'd6, 12'h066);

        $display("[TB] reset mid-operation");
        for (int i = 0; i < 16; i++) enq(20'd100 + 20'(i), 12'h200 + 12'(i));
        enq(20'd50, 12'hEEE);
        enq(20'd51, 12'hEEF);
        checkOutput("t6_drop", 64'(dropCount), 64'd3);
        for (int i = 0; i < 9; i++) deq(20'd100 + 20'(i), 12'h200 + 12'(i));
        checkOutput("t6_count", 64'(count), 64'd7);
        rst = 1'b0;
        @(posedge clk_dp);
        #1;
        rst = 1'b1;
        checkOutput("t6_rst_count", 64'(count), 64'd0);
        checkOutput("t6_rst_empty", 64'(empty), 64'd1);
        checkOutput("t6_rst_drop", 64'(dropCount), 64'd0);
        checkOutput("t6_rst_last_info", 64'(lastPktInfo), 64'd0);
        checkOutput("t6_rst_deq_valid", 64'(deqValid), 64'd0);
        checkOutput("t6_rst_deq_data", 64'(deqData), 64'd0);
        applyStimulus(1'b0, 20'h0, 12'h0, 1'b1);
        checkOutput("t6_post_deq_valid", 64'(deqValid), 64'd0);
        checkOutput("t6_post_count", 64'(count), 64'd0);

        repeat (3) @(posedge clk_dp);
        #1;
        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/pifo_rank_queue.md
Name: pifo_rank_queue

Overview:
Per-port push-in-first-out queue that sits directly downstream of the WFQ rank calculator. It accepts computed rank tuples {port_id, class, round} plus PIFO info and holds them sorted by round. It dequeues the minimum-round entry on request, and exports the last dequeued {round, info} word that the rank calculator uses as its per-port last_pkt_info input. One instance is built per output port (5 instances).

Parameters:
ROUND_WIDTH, 20, virtual-finish round field width
CLASS_WIDTH, 5, traffic class field width
PORT_ID_WIDTH, 3, encoded port id field width
PIFO_INFO_WIDTH, 12, opaque per-packet info carried alongside the rank
DEPTH, 16, number of queue slots
CNT_WIDTH, 5, occupancy counter width; must satisfy 2^CNT_WIDTH > DEPTH
DROP_CNT_WIDTH, 16, width of the saturating drop counter
ENTRY_WIDTH, PORT_ID_WIDTH+CLASS_WIDTH+ROUND_WIDTH+PIFO_INFO_WIDTH (40), stored entry width

Ports:
clk_dp  in  1  datapath clock
rst  in  1  reset; synchronous, active-low
enq_valid  in  1  enqueue strobe, one entry per cycle
enq_data  in  ENTRY_WIDTH  {port_id[39:37], class[36:32], round[31:12], info[11:0]}
deq_req  in  1  dequeue request
deq_valid  out  1  one-cycle pulse; deq_data is valid
deq_data  out  ENTRY_WIDTH  dequeued entry, same layout as enq_data
last_pkt_info  out  32  {round[31:12], info[11:0]} of the most recent dequeue
count  out  CNT_WIDTH  current occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0
drop_count  out  DROP_CNT_WIDTH  number of enqueues rejected while full, saturating

Behaviour:
- Reset (rst==0 at a clk_dp edge): all slots invalid. count=0, empty=1, full=0, deq_valid=0, deq_data=0, last_pkt_info=0, drop_count=0. Reset mid-operation flushes all contents; no dequeue pulse is emitted.
- Storage: slot 0 holds the head, i.e. the minimum round. Slots 0..count-1 are valid and held in non-decreasing round order.
- Comparison: round field only, unsigned. No wrap-around handling; round 0xFFFFF sorts last. Port_id, class and info never affect ordering.
- Enqueue only (enq_valid=1, deq_req=0 or empty, not full):
  - Insert position pos = number of valid entries with round <= new round, so ties are kept FIFO.
  - Slots pos..count-1 shift up by one; the new entry is written to slot pos; count increments.
  - The entry is visible to a dequeue on the next cycle.
- Dequeue only (deq_req=1, not empty):
  - Next edge: deq_data <= slot 0, deq_valid <= 1 for exactly one cycle, last_pkt_info <= {slot0.round, slot0.info}.
  - Slots shift down by one; count decrements.
- Simultaneous enqueue and dequeue (not empty):
  - The dequeue returns the pre-edge head, even if the new round is smaller.
  - The new entry is inserted among the remaining entries at position pos-1 (or 0 if pos==0).
  - count is unchanged. This is accepted even when full.
- Dequeue when empty: ignored. deq_valid stays 0; deq_data and last_pkt_info hold. A simultaneous enqueue proceeds as enqueue-only.
- Enqueue while full with no dequeue: entry dropped, contents unchanged. drop_count increments and saturates at all-ones.
- Latency: deq_req to deq_valid is 1 cycle. full/empty/count reflect the post-edge state combinationally from count.
- deq_data holds its last value when deq_valid=0. last_pkt_info holds until the next dequeue.

Decomposition:
- Shared package pifo_pkg holds:
  - width constants
  - enq/deq entry field offsets: PORT_ID_LSB=37, CLASS_LSB=32, ROUND_LSB=12, INFO_LSB=0
  - last_pkt_info field offsets: round [31:12], info [11:0]
  - packed entry typedef, DEPTH default
- One natural sub-module: pifo_slot.
  - Holds one valid bit and one entry.
  - Computes its own "round <= new round" compare.
  - Selects hold / shift-up-from-lower / shift-down-from-upper / load-new from control lines generated in pifo_rank_queue.
- Top level owns count, the position encoder, dequeue output registers and drop_count.

Test Plan:
1. Enqueue rounds 5, 2, 9 (info 0xA, 0xB, 0xC) on consecutive cycles, then 3 deq_req → deq_data rounds 2, 5, 9 with info 0xB, 0xA, 0xC. Final last_pkt_info = {20'd9, 12'hC}; empty=1.
2. Enqueue round 4 info 0x001, then round 4 info 0x002, then dequeue twice → info order 0x001 then 0x002 (FIFO among ties).
3. Enqueue 16 entries with rounds 16..1, then one more with round 0 → full=1, count=16, drop_count=1. Sixteen dequeues yield rounds 1..16 in order.
4. Queue holds {3, 7}; same cycle enqueue round 1 and deq_req → deq_data round 3, count stays 2. Next two dequeues yield 1 then 7.
5. deq_req while empty, last_pkt_info = {20'd9, 12'hC} → deq_valid stays 0, last_pkt_info and deq_data unchanged. Same with a simultaneous enqueue of round 6 → count=1, next dequeue returns 6.
6. Queue at count=7 with drop_count=3, drive rst=0 for one cycle → next cycle count=0, empty=1, drop_count=0, last_pkt_info=0, deq_valid=0. A later dequeue request produces no output.
